vliw_bundle_encoder: RTL and testbench

Packs a stream of single-slot operations into 3-slot VLIW bundles, producing the 64-bit `word` and 192-bit `data` buses consumed by the fetch stage. It sits between the instruction source and fetch. It closes a bundle when all three slots are full, on request, on an intra-bundle register hazard, or on idle timeout. Completed bundles are buffered in a small FIFO.

---
 rtl/vliw_bundle_encoder_pkg.sv | 64 ++++++
 rtl/vliw_bundle_fifo.sv | 55 +++++
 rtl/vliw_bundle_encoder.sv | 151 +++++++++++++++
 tb/tb_vliw_bundle_encoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_bundle_encoder_pkg.sv
// Shared opcode/register encodings, slot field offsets and the bundle
// encoding helper used by the VLIW bundle encoder.
package vliw_bundle_encoder_pkg;

  localparam int NUM_SLOTS = 3;
  localparam int OPW       = 4;
  localparam int REGW      = 4;
  localparam int DATAW     = 64;
  localparam int WORDW     = 64;
  localparam int BUNDLE_W  = WORDW + NUM_SLOTS * DATAW;

  typedef enum logic [OPW-1:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_LOAD, OP_STORE, OP_AND, OP_OR,
    OP_XOR, OP_NOT, OP_CMP, OP_JMP, OP_BEQ, OP_BNE, OP_SHIFTLEFT, OP_BSHIFTRIGHT
  } opcode_e;

  typedef enum logic [REGW-1:0] {
    REG0, REG1, REG2, REG3, REG4, REG5, REG6, REG7,
    REG8, REG9, REG10, REG11, REG12, REG13, REG14, REG15
  } regname_e;

  localparam logic [OPW-1:0] NOP_OP  = OP_NOP;
  localparam logic [OPW-1:0] LOAD_OP = OP_LOAD;

  // LSB positions of each field within the 64-bit bundle word
  localparam int SLOT1_OP = 55, SLOT1_SRC1 = 50, SLOT1_SRC2 = 45, SLOT1_DEST = 40;
  localparam int SLOT2_OP = 35, SLOT2_SRC1 = 30, SLOT2_SRC2 = 25, SLOT2_DEST = 20;
  localparam int SLOT3_OP = 15, SLOT3_SRC1 = 10, SLOT3_SRC2 = 5,  SLOT3_DEST = 0;

  localparam int SLOT_OP_LSB   [NUM_SLOTS] = '{SLOT1_OP,   SLOT2_OP,   SLOT3_OP};
  localparam int SLOT_SRC1_LSB [NUM_SLOTS] = '{SLOT1_SRC1, SLOT2_SRC1, SLOT3_SRC1};
  localparam int SLOT_SRC2_LSB [NUM_SLOTS] = '{SLOT1_SRC2, SLOT2_SRC2, SLOT3_SRC2};
  localparam int SLOT_DEST_LSB [NUM_SLOTS] = '{SLOT1_DEST, SLOT2_DEST, SLOT3_DEST};

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [REGW-1:0]  src1;
    logic [REGW-1:0]  src2;
    logic [REGW-1:0]  dest;
    logic [DATAW-1:0] data;
  } slot_t;

  // Invalid slots stay all-zero, which is the nop encoding.
  function automatic logic [BUNDLE_W-1:0] encode_bundle(
    input slot_t [NUM_SLOTS-1:0] s,
    input logic  [NUM_SLOTS-1:0] v
  );
    logic [WORDW-1:0]           w;
    logic [NUM_SLOTS*DATAW-1:0] d;
    w = '0;
    d = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (v[k]) begin
        w[SLOT_OP_LSB[k]   +: OPW]  = s[k].op;
        w[SLOT_SRC1_LSB[k] +: REGW] = s[k].src1;
        w[SLOT_SRC2_LSB[k] +: REGW] = s[k].src2;
        w[SLOT_DEST_LSB[k] +: REGW] = s[k].dest;
        if (s[k].op == LOAD_OP) d[DATAW*k +: DATAW] = s[k].data;
      end
    end
    return {d, w};
  endfunction

endpackage

// File: rtl/vliw_bundle_fifo.sv
// Synchronous bundle FIFO; same-cycle push and pop are both honoured
// even when full, and a pop on empty is ignored.
module vliw_bundle_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 256,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wptr, rptr;
  logic                        do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vliw_bundle_encoder.sv
// Packs single-slot operations into 3-slot VLIW bundles; closes on full,
// in_last, register hazard or idle timeout, and buffers bundles in a FIFO.
module vliw_bundle_encoder
  import vliw_bundle_encoder_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       in_op,
  input  logic [REGW-1:0]      in_src1,
  input  logic [REGW-1:0]      in_src2,
  input  logic [REGW-1:0]      in_dest,
  input  logic [DATAW-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORDW-1:0]     word,
  output logic [NUM_SLOTS*DATAW-1:0] data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(TIMEOUT + 2);
  localparam logic [IW-1:0] TO_LIM = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;

  slot_t [NUM_SLOTS-1:0] slot_q, slot_d;
  logic  [NUM_SLOTS-1:0] vld_q, vld_d, haz;
  logic  [1:0]           fill_q, fill_d;
  logic  [IW-1:0]        idle_q, idle_d;
  logic                  pend_q, pend_d;

  logic                  acc, space, push_req;
  logic  [BUNDLE_W-1:0]  push_bundle, f_dout;
  logic  [CW-1:0]        f_count;
  logic                  f_empty, f_full;
  slot_t                 in_slot;

  assign in_ready = !reset && !flush && (f_count < CW'(DEPTH)) && !pend_q;
  assign acc      = in_valid && in_ready;
  // A push can land this cycle if the FIFO has room or the head leaves now
  assign space    = !f_full || (out_ready && !f_empty);

  always_comb begin
    in_slot      = '0;
    in_slot.op   = in_op;
    in_slot.src1 = in_src1;
    in_slot.src2 = in_src2;
    in_slot.dest = in_dest;
    in_slot.data = (in_op == LOAD_OP) ? in_data : '0;
  end

  // RAW on either source or WAW against any filled non-nop slot
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_haz
    assign haz[k] = vld_q[k] && (slot_q[k].op != NOP_OP) &&
                    ((in_src1 == slot_q[k].dest) || (in_src2 == slot_q[k].dest) ||
                     (in_dest == slot_q[k].dest));
  end

  always_comb begin
    slot_d      = slot_q;
    vld_d       = vld_q;
    fill_d      = fill_q;
    idle_d      = idle_q;
    pend_d      = pend_q;
    push_req    = 1'b0;
    push_bundle = encode_bundle(slot_q, vld_q);

    if (pend_q) begin
      // deferred single-slot bundle from a hazard close with in_last
      push_req = 1'b1;
      if (space) begin
        fill_d = '0;
        vld_d  = '0;
        pend_d = 1'b0;
      end
    end else if (acc && |haz) begin
      push_req  = 1'b1;
      slot_d    = '0;
      slot_d[0] = in_slot;
      vld_d     = 3'b001;
      fill_d    = 2'd1;
      idle_d    = '0;
      pend_d    = in_last;
    end else if (acc) begin
      idle_d = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (2'(k) == fill_q) begin
          slot_d[k] = in_slot;
          vld_d[k]  = 1'b1;
        end
      end
      if (fill_q == 2'd2 || in_last) begin
        push_req    = 1'b1;
        push_bundle = encode_bundle(slot_d, vld_d);
        fill_d      = '0;
        vld_d       = '0;
      end else begin
        fill_d = fill_q + 2'd1;
      end
    end else if (fill_q != '0 && TIMEOUT != 0) begin
      if (idle_q >= TO_LIM) begin
        push_req = 1'b1;
        if (space) begin
          fill_d = '0;
          vld_d  = '0;
          idle_d = '0;
        end
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      slot_q <= '0;
      vld_q  <= '0;
      fill_q <= '0;
      idle_q <= '0;
      pend_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      vld_q  <= vld_d;
      fill_q <= fill_d;
      idle_q <= idle_d;
      pend_q <= pend_d;
    end
  end

  vliw_bundle_fifo #(.DEPTH(DEPTH), .WIDTH(BUNDLE_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .push  (push_req && !flush),
    .din   (push_bundle),
    .pop   (out_ready),
    .dout  (f_dout),
    .count (f_count),
    .empty (f_empty),
    .full  (f_full)
  );

  assign out_valid = !f_empty;
  assign word      = f_empty ? '0 : f_dout[WORDW-1:0];
  assign data      = f_empty ? '0 : f_dout[BUNDLE_W-1:WORDW];

endmodule

// File: tb/tb_vliw_bundle_encoder.sv
// Self-checking bench: directed scenarios plus randomized traffic against
// a queue-based bundle model.
module tb_vliw_bundle_encoder;

  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 4;

  logic         clock = 1'b0;
  logic         reset, flush, in_valid, in_last, out_ready;
  logic [3:0]   in_op, in_src1, in_src2, in_dest;
  logic [63:0]  in_data;
  logic         in_ready, out_valid, in_ready0, out_valid0;
  logic [63:0]  word, word0;
  logic [191:0] data, data0;

  always #5 clock = ~clock;

  vliw_bundle_encoder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2),
    .in_dest(in_dest), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .word(word), .data(data));

  vliw_bundle_encoder #(.DEPTH(3), .TIMEOUT(0)) dut0 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready0), .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2),
    .in_dest(in_dest), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .word(word0), .data(data0));

  typedef struct {
    logic [3:0]  op, s1, s2, d;
    logic [63:0] dat;
  } op_t;

  op_t          asmq[$];
  logic [255:0] fq[$];
  int           idle;
  bit           pend;
  int           checks = 0, errors = 0;
  logic [255:0] exp_b;

  // Bundle = {data[191:0], word[63:0]} built from the field map
  function automatic logic [255:0] build();
    logic [63:0]  w = '0;
    logic [191:0] bd = '0;
    foreach (asmq[k]) begin
      w = w | (64'(asmq[k].op) << (55 - 20*k)) | (64'(asmq[k].s1) << (50 - 20*k))
            | (64'(asmq[k].s2) << (45 - 20*k)) | (64'(asmq[k].d)  << (40 - 20*k));
      if (asmq[k].op == 4'd4) bd[64*k +: 64] = asmq[k].dat;
    end
    return {bd, w};
  endfunction

  function automatic bit mready();
    return !flush && (fq.size() < DEPTH) && !pend;
  endfunction

  function automatic logic [255:0] head();
    return (fq.size() > 0) ? fq[0] : '0;
  endfunction

  task automatic mclear();
    asmq.delete(); fq.delete(); idle = 0; pend = 0;
  endtask

  task automatic drive(input logic [3:0] op, s1, s2, d, input logic [63:0] dat, input bit last);
    in_valid = 1; in_op = op; in_src1 = s1; in_src2 = s2; in_dest = d;
    in_data = dat; in_last = last;
  endtask

  task automatic go_idle();
    in_valid = 0; in_last = 0; in_op = 0; in_src1 = 0; in_src2 = 0; in_dest = 0; in_data = 0;
  endtask

  // Advance the model by one cycle using current inputs, then clock the DUT.
  task automatic step();
    bit acc, pop, space, haz;
    op_t o;
    #1;
    if (reset || flush) mclear();
    else begin
      acc   = in_valid && mready();
      pop   = out_ready && (fq.size() > 0);
      space = (fq.size() < DEPTH) || pop;
      if (pop) void'(fq.pop_front());
      o = '{in_op, in_src1, in_src2, in_dest, in_data};
      if (pend) begin
        if (space) begin fq.push_back(build()); asmq.delete(); pend = 0; end
      end else if (acc) begin
        idle = 0;
        haz  = 0;
        foreach (asmq[i])
          if (asmq[i].op != 0 && (asmq[i].d == o.s1 || asmq[i].d == o.s2 || asmq[i].d == o.d)) haz = 1;
        if (haz) begin
          fq.push_back(build()); asmq.delete(); asmq.push_back(o); pend = in_last;
        end else begin
          asmq.push_back(o);
          if (asmq.size() == 3 || in_last) begin fq.push_back(build()); asmq.delete(); end
        end
      end else if (asmq.size() > 0 && TIMEOUT > 0) begin
        if (idle + 1 >= TIMEOUT) begin
          if (space) begin fq.push_back(build()); asmq.delete(); idle = 0; end
          else idle = TIMEOUT;
        end else idle++;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; out_ready = 0; go_idle();
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0 || word !== '0 || data !== '0) begin
      errors++; $display("FAIL reset_outputs valid=%b word=%h data=%h exp=0", out_valid, word, data); end
    reset = 0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_full_bundle();
    logic [63:0] ew;
    ew = {5'b0, 4'd1,1'b0,4'd1,1'b0,4'd2,1'b0,4'd3,1'b0,
                4'd2,1'b0,4'd4,1'b0,4'd5,1'b0,4'd6,1'b0,
                4'd3,1'b0,4'd7,1'b0,4'd8,1'b0,4'd9};
    out_ready = 0;
    drive(4'd1, 4'd1, 4'd2, 4'd3, 64'hFFFF, 0); step();
    drive(4'd2, 4'd4, 4'd5, 4'd6, 64'h1234, 0); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got=%b exp=0", out_valid); end
    drive(4'd3, 4'd7, 4'd8, 4'd9, 64'h5678, 0); step();
    go_idle();
    checks++; if (out_valid !== 1'b1 || word !== ew || data !== '0) begin
      errors++; $display("FAIL full_bundle valid=%b word=%h exp=%h data=%h", out_valid, word, ew, data); end
    checks++; if (word[58:55] !== 4'd1 || word[38:35] !== 4'd2 || word[18:15] !== 4'd3 || word[3:0] !== 4'd9) begin
      errors++; $display("FAIL full_fields word=%h", word); end
    out_ready = 1; step(); out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_pop valid=%b exp=0", out_valid); end
  endtask

  task automatic test_load();
    out_ready = 0;
    drive(4'd4, 4'd0, 4'd0, 4'd2, 64'hDEAD_BEEF_0000_0001, 1); step(); go_idle();
    checks++; if (out_valid !== 1'b1 || data[63:0] !== 64'hDEAD_BEEF_0000_0001 || data[191:64] !== '0) begin
      errors++; $display("FAIL load_data valid=%b data=%h", out_valid, data); end
    checks++; if (word[58:55] !== 4'd4 || word[43:40] !== 4'd2 || word[38:0] !== '0) begin
      errors++; $display("FAIL load_word got=%h", word); end
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_hazard_timeout();
    logic [63:0] ew;
    ew = {5'b0, 4'd1,1'b0,4'd1,1'b0,4'd2,1'b0,4'd3, 40'b0};
    out_ready = 0;
    drive(4'd1, 4'd1, 4'd2, 4'd3, 0, 0); step();
    drive(4'd2, 4'd3, 4'd4, 4'd5, 0, 0); step();
    go_idle();
    checks++; if (out_valid !== 1'b1 || word !== ew) begin
      errors++; $display("FAIL hazard_close valid=%b word=%h exp=%h", out_valid, word, ew); end
    out_ready = 1; step(); out_ready = 0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL timeout_early valid=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || word[58:55] !== 4'd2 || word[53:50] !== 4'd3 || word[38:0] !== '0) begin
      errors++; $display("FAIL timeout_close valid=%b word=%h", out_valid, word); end
    exp_b = head();
    checks++; if ({data, word} !== exp_b) begin errors++; $display("FAIL timeout_model got=%h exp=%h", word, exp_b[63:0]); end
    step(); step(); step();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL timeout_disabled valid=%b exp=0", out_valid0); end
    flush = 1; step(); flush = 0;
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    drive(4'd1, 4'd1, 4'd2, 4'd3, 0, 1); step();
    drive(4'd2, 4'd4, 4'd5, 4'd6, 0, 1); step();
    drive(4'd3, 4'd7, 4'd8, 4'd9, 0, 1); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    step();
    checks++; if (word[58:55] !== 4'd1 || {data, word} !== head()) begin
      errors++; $display("FAIL bp_head_a got=%h", word); end
    go_idle(); out_ready = 1; step(); out_ready = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_ready got=%b exp=1", in_ready); end
    checks++; if (word[58:55] !== 4'd2 || word[43:40] !== 4'd6) begin
      errors++; $display("FAIL bp_order got=%h", word); end
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_hazard_last();
    out_ready = 0;
    drive(4'd1, 4'd1, 4'd2, 4'd3, 0, 0); step();
    drive(4'd2, 4'd3, 4'd4, 4'd5, 0, 1); step();
    go_idle(); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL haz_last_ready got=%b exp=0", in_ready); end
    out_ready = 1; step();
    exp_b = head();
    checks++; if (out_valid !== 1'b1 || word[58:55] !== 4'd2 || {data, word} !== exp_b) begin
      errors++; $display("FAIL haz_last_second valid=%b word=%h exp=%h", out_valid, word, exp_b[63:0]); end
    step(); out_ready = 0;
  endtask

  task automatic test_flush_mid(input bit use_reset);
    out_ready = 0;
    drive(4'd1, 4'd1, 4'd2, 4'd3, 0, 1); step();
    drive(4'd5, 4'd4, 4'd5, 4'd6, 0, 0); step();
    drive(4'd6, 4'd7, 4'd8, 4'd9, 0, 0); step();
    go_idle();
    if (use_reset) reset = 1; else flush = 1;
    step(); reset = 0; flush = 0;
    checks++; if (out_valid !== 1'b0 || word !== '0 || data !== '0) begin
      errors++; $display("FAIL clear_mid rst=%0d valid=%b word=%h", use_reset, out_valid, word); end
    drive(4'd7, 4'd10, 4'd11, 4'd12, 0, 1); step(); go_idle();
    checks++; if (out_valid !== 1'b1 || word[58:55] !== 4'd7 || word[38:0] !== '0) begin
      errors++; $display("FAIL clear_fill rst=%0d valid=%b word=%h", use_reset, out_valid, word); end
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) != 0)
        drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
              4'($urandom_range(0, 7)), {$urandom, $urandom}, ($urandom_range(0, 5) == 0));
      else go_idle();
      #1;
      checks++; if (in_ready !== mready()) begin
        errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, in_ready, mready()); end
      step();
      exp_b = head();
      checks++; if (out_valid !== (fq.size() > 0) || {data, word} !== exp_b) begin
        errors++; $display("FAIL rand_out cyc=%0d valid=%b word=%h exp=%h", c, out_valid, word, exp_b[63:0]); end
    end
    flush = 0; go_idle();
  endtask

  initial begin
    test_reset();
    test_full_bundle();
    test_load();
    test_hazard_timeout();
    test_backpressure();
    test_hazard_last();
    test_flush_mid(0);
    test_flush_mid(1);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
